// File: rtl/alu_cmd_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_cmd_sequencer_if : request channel into the ALU command sequencer |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface alu_cmd_sequencer_if #(
  parameter int WIDTH  = 8,
  parameter int CWIDTH = 4
);
  logic              req_valid;
  logic              req_ready;
  logic [WIDTH-1:0]  req_opa;
  logic [WIDTH-1:0]  req_opb;
  logic [CWIDTH-1:0] req_cmd;
  logic              req_mode;
  logic              req_cin;
  logic [1:0]        req_iv;
  logic [3:0]        req_gap;

  modport master (
    output req_valid, req_opa, req_opb, req_cmd, req_mode, req_cin, req_iv, req_gap,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_opa, req_opb, req_cmd, req_mode, req_cin, req_iv, req_gap,
    output req_ready
  );
endinterface
`default_nettype wire

// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_cmd_sequencer : FIFO-buffered ALU issue stage with split beats    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module alu_cmd_sequencer #(
  parameter int WIDTH   = 8,
  parameter int CWIDTH  = 4,
  parameter int DEPTH   = 4,
  parameter int RES_LAT = 1,
  parameter int MUL_LAT = 2
) (
  input  wire logic               CLK,
  input  wire logic               RST,
  alu_cmd_sequencer_if.slave      req,
  input  wire logic               hold,
  output logic                    CE,
  output logic [1:0]              INP_VALID,
  output logic [WIDTH-1:0]        OPA,
  output logic [WIDTH-1:0]        OPB,
  output logic [CWIDTH-1:0]       CMD,
  output logic                    MODE,
  output logic                    CIN,
  output logic                    issue_done,
  output logic                    busy,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int AW      = $clog2(DEPTH);
  localparam int LAT_MAX = (MUL_LAT > RES_LAT) ? MUL_LAT : RES_LAT;
  localparam int LW      = $clog2(LAT_MAX) + 1;

  localparam logic [AW:0]     FULL_LEVEL = (AW+1)'(DEPTH);
  localparam logic [LW-1:0]   RES_M1     = LW'(RES_LAT - 1);
  localparam logic [LW-1:0]   MUL_M1     = LW'(MUL_LAT - 1);
  localparam logic [CWIDTH-1:0] CMD_MUL_A = CWIDTH'(9);
  localparam logic [CWIDTH-1:0] CMD_MUL_B = CWIDTH'(10);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_BEAT_A = 3'd1,
    S_GAP    = 3'd2,
    S_BEAT_B = 3'd3,
    S_WAIT   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0]  opa;
    logic [WIDTH-1:0]  opb;
    logic [CWIDTH-1:0] cmd;
    logic              mode;
    logic              cin;
    logic [1:0]        iv;
    logic [3:0]        gap;
  } req_t;

  req_t            mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;

  state_t          state;
  logic [WIDTH-1:0] cur_opb;
  logic [3:0]      gap_cnt;
  logic [LW-1:0]   lat_cnt;

  req_t            new_entry;
  req_t            head;
  logic            push;
  logic            pop;
  logic            head_split;
  logic            head_mul;

  assign new_entry = '{opa:  req.req_opa,  opb: req.req_opb, cmd: req.req_cmd,
                       mode: req.req_mode, cin: req.req_cin, iv:  req.req_iv,
                       gap:  req.req_gap};
  assign head      = mem[rd_ptr];

  assign req.req_ready = (count < FULL_LEVEL);
  assign push          = req.req_valid && req.req_ready;
  assign pop           = (state == S_IDLE) && !hold && (count != '0);

  assign head_split = (head.iv == 2'b11) && (head.gap != 4'd0);
  assign head_mul   = head.mode && ((head.cmd == CMD_MUL_A) || (head.cmd == CMD_MUL_B));

  assign CE    = ~hold;
  assign busy  = (state != S_IDLE);
  assign level = count;

  // Storage carries no reset; only pointers and occupancy define validity.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= new_entry;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      state      <= S_IDLE;
      cur_opb    <= '0;
      gap_cnt    <= '0;
      lat_cnt    <= '0;
      INP_VALID  <= 2'b00;
      OPA        <= '0;
      OPB        <= '0;
      CMD        <= '0;
      MODE       <= 1'b0;
      CIN        <= 1'b0;
      issue_done <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      // hold freezes the whole issue pipeline, including the registered ALU drive.
      if (!hold) begin
        case (state)
          S_IDLE: begin
            issue_done <= 1'b0;
            if (count != '0) begin
              cur_opb <= head.opb;
              gap_cnt <= head.gap - 4'd1;
              lat_cnt <= head_mul ? MUL_M1 : RES_M1;
              OPA     <= head.opa;
              CMD     <= head.cmd;
              MODE    <= head.mode;
              CIN     <= head.cin;
              if (head_split) begin
                INP_VALID <= 2'b01;
                OPB       <= '0;
                state     <= S_BEAT_A;
              end else begin
                INP_VALID <= head.iv;
                OPB       <= head.opb;
                state     <= S_BEAT_B;
              end
            end
          end

          S_BEAT_A: begin
            if (gap_cnt == 4'd0) begin
              INP_VALID <= 2'b10;
              OPB       <= cur_opb;
              state     <= S_BEAT_B;
            end else begin
              INP_VALID <= 2'b00;
              gap_cnt   <= gap_cnt - 4'd1;
              state     <= S_GAP;
            end
          end

          S_GAP: begin
            if (gap_cnt == 4'd0) begin
              INP_VALID <= 2'b10;
              OPB       <= cur_opb;
              state     <= S_BEAT_B;
            end else begin
              gap_cnt <= gap_cnt - 4'd1;
            end
          end

          S_BEAT_B: begin
            INP_VALID <= 2'b00;
            state     <= S_WAIT;
          end

          // WAIT spans exactly the selected latency, so DONE lines up with RES.
          S_WAIT: begin
            if (lat_cnt == '0) begin
              issue_done <= 1'b1;
              state      <= S_DONE;
            end else begin
              lat_cnt <= lat_cnt - 1'b1;
            end
          end

          S_DONE: begin
            issue_done <= 1'b0;
            state      <= S_IDLE;
          end

          default: begin
            INP_VALID  <= 2'b00;
            issue_done <= 1'b0;
            state      <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | tb_alu_cmd_sequencer : directed bench for alu_cmd_sequencer           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_alu_cmd_sequencer;

  localparam int WIDTH  = 8;
  localparam int CWIDTH = 4;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              hold;
  logic              ce;
  logic [1:0]        inp_valid;
  logic [WIDTH-1:0]  opa;
  logic [WIDTH-1:0]  opb;
  logic [CWIDTH-1:0] cmd;
  logic              mode;
  logic              cin;
  logic              issue_done;
  logic              busy;
  logic [2:0]        level;

  int total = 0;
  int bad   = 0;
  int dones = 0;
  logic [7:0] issued [$];

  always #5 clk = ~clk;

  alu_cmd_sequencer_if #(.WIDTH(WIDTH), .CWIDTH(CWIDTH)) bus ();

  alu_cmd_sequencer #(
    .WIDTH(WIDTH), .CWIDTH(CWIDTH), .DEPTH(DEPTH), .RES_LAT(1), .MUL_LAT(2)
  ) dut (
    .CLK(clk), .RST(rst), .req(bus), .hold(hold), .CE(ce),
    .INP_VALID(inp_valid), .OPA(opa), .OPB(opb), .CMD(cmd), .MODE(mode),
    .CIN(cin), .issue_done(issue_done), .busy(busy), .level(level)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_mon();
    step();
    if (inp_valid == 2'b11) issued.push_back(opa);
    if (issue_done) dones++;
  endtask

  task automatic set_req(input logic [7:0] a, input logic [7:0] b, input logic [3:0] c,
                         input logic m, input logic ci, input logic [1:0] iv,
                         input logic [3:0] g);
    bus.req_valid = 1'b1;
    bus.req_opa   = a;
    bus.req_opb   = b;
    bus.req_cmd   = c;
    bus.req_mode  = m;
    bus.req_cin   = ci;
    bus.req_iv    = iv;
    bus.req_gap   = g;
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [3:0] c,
                      input logic m, input logic ci, input logic [1:0] iv,
                      input logic [3:0] g);
    set_req(a, b, c, m, ci, iv, g);
    step();
    bus.req_valid = 1'b0;
  endtask

  task automatic beat(input string tag, input logic [1:0] iv, input logic [7:0] a,
                      input logic [7:0] b);
    chk({tag, "_iv"},  32'(inp_valid), 32'(iv));
    chk({tag, "_opa"}, 32'(opa),       32'(a));
    chk({tag, "_opb"}, 32'(opb),       32'(b));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst  = 1'b1;
    hold = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_opa = '0; bus.req_opb = '0; bus.req_cmd = '0;
    bus.req_mode = 1'b0; bus.req_cin = 1'b0; bus.req_iv = '0; bus.req_gap = '0;
    #2;
    beat("rst", 2'b00, 8'h00, 8'h00);
    chk("rst_busy",  32'(busy),       32'd0);
    chk("rst_level", 32'(level),      32'd0);
    chk("rst_ce",    32'(ce),         32'd1);
    chk("rst_done",  32'(issue_done), 32'd0);
    chk("rst_ready", 32'(bus.req_ready), 32'd1);
    step(); step();
    rst = 1'b0;
    step();

    // 1: single-beat add
    push(8'h0F, 8'h01, 4'd0, 1'b1, 1'b0, 2'b11, 4'd0);
    chk("t1_level", 32'(level), 32'd1);
    chk("t1_idle",  32'(busy),  32'd0);
    step();
    beat("t1_beat", 2'b11, 8'h0F, 8'h01);
    chk("t1_mode",  32'(mode),  32'd1);
    chk("t1_busy",  32'(busy),  32'd1);
    chk("t1_pop",   32'(level), 32'd0);
    step();
    chk("t1_wait_iv",   32'(inp_valid),  32'd0);
    chk("t1_wait_done", 32'(issue_done), 32'd0);
    step();
    chk("t1_done", 32'(issue_done), 32'd1);
    chk("t1_held_opa", 32'(opa), 32'h0F);
    step();
    chk("t1_done_clr", 32'(issue_done), 32'd0);
    chk("t1_idle2",    32'(busy),       32'd0);

    // 2: split request, gap 5
    push(8'h03, 8'h04, 4'd0, 1'b1, 1'b0, 2'b11, 4'd5);
    step();
    beat("t2_a", 2'b01, 8'h03, 8'h00);
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("t2_gap%0d_iv", i), 32'(inp_valid), 32'd0);
      chk($sformatf("t2_gap%0d_opa", i), 32'(opa), 32'h03);
    end
    step();
    beat("t2_b", 2'b10, 8'h03, 8'h04);
    step();
    chk("t2_wait_done", 32'(issue_done), 32'd0);
    step();
    chk("t2_done", 32'(issue_done), 32'd1);
    step();

    // 3: multiply waits MUL_LAT
    push(8'h02, 8'h03, 4'd9, 1'b1, 1'b1, 2'b11, 4'd0);
    step();
    beat("t3_beat", 2'b11, 8'h02, 8'h03);
    chk("t3_cmd", 32'(cmd), 32'd9);
    chk("t3_cin", 32'(cin), 32'd1);
    step();
    chk("t3_wait1", 32'(issue_done), 32'd0);
    step();
    chk("t3_wait2", 32'(issue_done), 32'd0);
    step();
    chk("t3_done", 32'(issue_done), 32'd1);
    step();
    chk("t3_idle", 32'(busy), 32'd0);

    // 4: fill the FIFO behind a long split request
    issued.delete();
    dones = 0;
    push(8'hAA, 8'hBB, 4'd1, 1'b0, 1'b0, 2'b11, 4'd15);
    step_mon();
    chk("t4_long_a", 32'(inp_valid), 32'd1);
    for (int i = 0; i < 4; i++) begin
      set_req(8'(8'h10 + i), 8'h01, 4'd1, 1'b0, 1'b0, 2'b11, 4'd0);
      step_mon();
    end
    chk("t4_full_level", 32'(level), 32'd4);
    chk("t4_full_ready", 32'(bus.req_ready), 32'd0);
    set_req(8'h14, 8'h01, 4'd1, 1'b0, 1'b0, 2'b11, 4'd0);
    step_mon();
    chk("t4_held_level", 32'(level), 32'd4);
    n = 0;
    while (!bus.req_ready && n < 64) begin
      step_mon();
      n++;
    end
    chk("t4_ready_timeout", 32'(n < 64), 32'd1);
    step_mon();
    bus.req_valid = 1'b0;
    n = 0;
    while (dones < 6 && n < 100) begin
      step_mon();
      n++;
    end
    chk("t4_done_timeout", 32'(n < 100), 32'd1);
    chk("t4_dones",  32'(dones), 32'd6);
    chk("t4_issued", 32'(issued.size()), 32'd5);
    for (int i = 0; i < 5 && i < issued.size(); i++) begin
      chk($sformatf("t4_order%0d", i), 32'(issued[i]), 32'(8'h10 + i));
    end
    step();
    chk("t4_idle",  32'(busy),  32'd0);
    chk("t4_empty", 32'(level), 32'd0);

    // 5: hold during GAP, plus a push while held
    push(8'h05, 8'h06, 4'd0, 1'b1, 1'b0, 2'b11, 4'd4);
    step();
    beat("t5_a", 2'b01, 8'h05, 8'h00);
    step();
    chk("t5_g1_iv", 32'(inp_valid), 32'd0);
    hold = 1'b1;
    set_req(8'h77, 8'h08, 4'd2, 1'b0, 1'b0, 2'b00, 4'd0);
    #1;
    chk("t5_ce0", 32'(ce), 32'd0);
    step();
    bus.req_valid = 1'b0;
    chk("t5_push_in_hold", 32'(level), 32'd1);
    chk("t5_h1_ce", 32'(ce), 32'd0);
    step();
    chk("t5_h2_iv",  32'(inp_valid), 32'd0);
    chk("t5_h2_opa", 32'(opa), 32'h05);
    step();
    hold = 1'b0;
    #1;
    chk("t5_ce1", 32'(ce), 32'd1);
    step();
    chk("t5_g2_iv", 32'(inp_valid), 32'd0);
    step();
    chk("t5_g3_iv", 32'(inp_valid), 32'd0);
    step();
    beat("t5_b", 2'b10, 8'h05, 8'h06);
    step();
    step();
    chk("t5_done", 32'(issue_done), 32'd1);
    step();
    chk("t5_idle_level", 32'(level), 32'd1);
    step();
    beat("t5_iv00", 2'b00, 8'h77, 8'h08);
    chk("t5_iv00_cmd",  32'(cmd),  32'd2);
    chk("t5_iv00_busy", 32'(busy), 32'd1);
    step();
    step();
    chk("t5_iv00_done", 32'(issue_done), 32'd1);
    step();

    // 6: reset during WAIT
    push(8'h21, 8'h02, 4'd0, 1'b1, 1'b0, 2'b11, 4'd0);
    set_req(8'h31, 8'h03, 4'd0, 1'b1, 1'b0, 2'b11, 4'd0);
    step();
    bus.req_valid = 1'b0;
    step();
    chk("t6_wait_busy",  32'(busy),  32'd1);
    chk("t6_wait_level", 32'(level), 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_rst_busy",  32'(busy),      32'd0);
    chk("t6_rst_level", 32'(level),     32'd0);
    chk("t6_rst_iv",    32'(inp_valid), 32'd0);
    chk("t6_rst_opa",   32'(opa),       32'd0);
    step();
    chk("t6_rst_done", 32'(issue_done), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("t6_quiet%0d", i), 32'({issue_done, busy}), 32'd0);
    end
    push(8'h41, 8'h05, 4'd0, 1'b1, 1'b0, 2'b11, 4'd0);
    step();
    beat("t6_new", 2'b11, 8'h41, 8'h05);
    step();
    step();
    chk("t6_new_done", 32'(issue_done), 32'd1);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
